// File: rtl/reg_alu.sv
// reg_alu: 8 x 16-bit register file with two combinational read ports, one
// synchronous write port and a 2-bit-opcode ALU on the read-port outputs.
// The write-data mux lets reg[wr_addr] <= reg[a] op reg[b] complete in one cycle.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   reset      - synchronous, active-high; clears every register
//   sel        - write-data select: 0 = d_in, 1 = ALU result
//   wr         - write enable
//   op         - ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
//   rd_addr_a  - read port A address (ALU operand A)
//   rd_addr_b  - read port B address (ALU operand B)
//   wr_addr    - write address
//   d_in       - external write data
//   d_out_a    - reg[rd_addr_a], combinational
//   d_out_b    - reg[rd_addr_b], combinational
//   cout       - ALU carry out, combinational
module reg_alu #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             wr,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out_a,
  output logic [WIDTH-1:0] d_out_b,
  output logic             cout
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] wr_data;

  // Read ports: no write bypass, so a register being written shows its old
  // value until the edge.
  assign d_out_a = regs_q[rd_addr_a];
  assign d_out_b = regs_q[rd_addr_b];

  // ALU is always active; the top bit of the 17-bit result is the carry.
  // SUB is A + ~B + 1, so cout = 1 means no borrow.
  always_comb begin
    alu_sum = '0;
    case (alu_op_e'(op))
      OP_ADD:  alu_sum = {1'b0, d_out_a} + {1'b0, d_out_b};
      OP_SUB:  alu_sum = {1'b0, d_out_a} + {1'b0, ~d_out_b} + (WIDTH+1)'(1);
      OP_AND:  alu_sum = {1'b0, d_out_a & d_out_b};
      OP_OR:   alu_sum = {1'b0, d_out_a | d_out_b};
      default: alu_sum = '0;
    endcase
  end

  assign alu_y   = alu_sum[WIDTH-1:0];
  assign cout    = alu_sum[WIDTH];
  assign wr_data = sel ? alu_y : d_in;

  // Next-state for the register file. Each entry compares its own index
  // against wr_addr, so an unknown address can only affect the matching
  // entry and never silently overwrites the others. Reset wins over wr.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (reset) begin
        regs_d[i] = '0;
      end else if (wr && (wr_addr == AW'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_reg_alu.sv
module tb_reg_alu;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             reset;
  logic             sel;
  logic             wr;
  logic [1:0]       op;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out_a;
  logic [WIDTH-1:0] d_out_b;
  logic             cout;

  typedef struct {
    string      tag;
    logic [WIDTH-1:0] value;
  } expect_t;

  expect_t          scoreboard[$];
  logic [WIDTH-1:0] model [DEPTH];
  int               testsRun;
  int               testsFailed;

  reg_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .wr        (wr),
    .op        (op),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .cout      (cout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record an expected value at the moment its stimulus is driven.
  task automatic expectValue(input string tag, input logic [WIDTH-1:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against what the DUT shows.
  task automatic checkOutput(input logic [WIDTH-1:0] observed);
    expect_t e;
    testsRun++;
    if (scoreboard.size() == 0) begin
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty observed=%h required=<none>", observed);
    end else begin
      e = scoreboard.pop_front();
      assert (observed === e.value) else begin
        testsFailed++;
        $error("[TB] FAIL %s observed=%h required=%h", e.tag, observed, e.value);
      end
    end
  endtask

  // Drive one cycle's worth of inputs just after the falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic w,
                               input logic [1:0] o, input logic [AW-1:0] ra,
                               input logic [AW-1:0] rb, input logic [AW-1:0] wa,
                               input logic [WIDTH-1:0] din);
    @(negedge clk);
    reset     = r;
    sel       = s;
    wr        = w;
    op        = o;
    rd_addr_a = ra;
    rd_addr_b = rb;
    wr_addr   = wa;
    d_in      = din;
    #1;
  endtask

  // Let the driven cycle commit, then release wr/reset.
  task automatic clockEdge();
    @(posedge clk);
    #1;
    wr    = 1'b0;
    reset = 1'b0;
  endtask

  task automatic writeDin(input logic [AW-1:0] wa, input logic [WIDTH-1:0] din);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, wa, din);
    clockEdge();
    model[wa] = din;
  endtask

  // Read every register through port A and B against the bench's own copy.
  task automatic checkAllRegs(input string phase);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, AW'(i), AW'(DEPTH - 1 - i), 3'd0, 16'h0000);
      expectValue($sformatf("%s_R%0d_a", phase, i), model[i]);
      checkOutput(d_out_a);
      expectValue($sformatf("%s_R%0d_b", phase, DEPTH - 1 - i), model[DEPTH - 1 - i]);
      checkOutput(d_out_b);
    end
  endtask

  // ALU write: check cout before the edge, then the destination after it.
  task automatic aluWrite(input string tag, input logic [1:0] o,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input logic [AW-1:0] wa, input logic [WIDTH-1:0] expY,
                          input logic expCout);
    applyStimulus(1'b0, 1'b1, 1'b1, o, ra, rb, wa, 16'hDEAD);
    expectValue({tag, "_cout"}, {15'd0, expCout});
    checkOutput({15'd0, cout});
    clockEdge();
    model[wa] = expY;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, wa, wa, 3'd0, 16'h0000);
    expectValue({tag, "_result"}, expY);
    checkOutput(d_out_a);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    sel         = 1'b0;
    wr          = 1'b0;
    op          = 2'b00;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    wr_addr     = '0;
    d_in        = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset clears everything
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000);
    clockEdge();
    checkAllRegs("reset");

    // External writes, one per cycle
    writeDin(3'd3, 16'hCDEF);
    writeDin(3'd7, 16'h3210);
    writeDin(3'd5, 16'h4567);
    writeDin(3'd1, 16'hBA98);
    writeDin(3'd2, 16'h0001);
    writeDin(3'd4, 16'h1111);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'd3, 3'd7, 3'd0, 16'h0000);
    expectValue("read_a_R3", 16'hCDEF);
    checkOutput(d_out_a);
    expectValue("read_b_R7", 16'h3210);
    checkOutput(d_out_b);

    // ADD without and with carry out
    aluWrite("add_R1_R5", 2'b00, 3'd1, 3'd5, 3'd3, 16'hFFFF, 1'b0);
    aluWrite("add_wrap",  2'b00, 3'd3, 3'd2, 3'd6, 16'h0000, 1'b1);

    // SUB with borrow (into R0, which is ordinary storage), then without
    aluWrite("sub_borrow",    2'b01, 3'd7, 3'd5, 3'd0, 16'hECA9, 1'b0);
    aluWrite("sub_no_borrow", 2'b01, 3'd5, 3'd7, 3'd7, 16'h1357, 1'b1);

    // Logic ops; OR writes back into its own source R1
    aluWrite("and_R3_R7", 2'b10, 3'd3, 3'd7, 3'd5, 16'h1357, 1'b0);
    aluWrite("or_R1_R5",  2'b11, 3'd1, 3'd5, 3'd1, 16'hBBDF, 1'b0);

    // wr=0 leaves the whole file alone whatever sel/op/d_in say
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 3'd1, 3'd2, 16'hFACE);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 3'd0, 3'd0, 3'd6, 16'hBEEF);
    clockEdge();
    checkAllRegs("nowrite");

    // Read-during-write: old value before the edge, new value after
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'd2, 3'd2, 3'd2, 16'h5A5A);
    expectValue("rdw_before", 16'h0001);
    checkOutput(d_out_a);
    @(posedge clk);
    #1;
    model[2] = 16'h5A5A;
    expectValue("rdw_after", 16'h5A5A);
    checkOutput(d_out_a);
    wr = 1'b0;

    // Reset with a pending write: reset wins and R4 ends up cleared too
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 3'd4, 3'd4, 16'hAAAA);
    clockEdge();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    checkAllRegs("midreset");

    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d required=0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_alu.md
Name: reg_alu

Overview:
- 8-entry x 16-bit register file with two combinational read ports and one synchronous write port.
- A 2-bit-opcode ALU combines the two read-port values.
- The write-data mux (sel) chooses between the external input d_in and the ALU result, so reg[wr_addr] <= reg[a] op reg[b] completes in one cycle.
- Used as the datapath core for simple accumulator/ALU exercises.

Parameters:
- WIDTH, 16, data width of registers, d_in, d_out_a/b and the ALU.
- DEPTH, 8, number of registers.
- AW, 3, address width (log2 DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears every register.
- sel  in  1  write-data select: 0 = d_in, 1 = ALU result.
- wr  in  1  write enable.
- op  in  2  ALU opcode.
- rd_addr_a  in  3  read port A address.
- rd_addr_b  in  3  read port B address.
- wr_addr  in  3  write address.
- d_in  in  16  external write data.
- d_out_a  out  16  reg[rd_addr_a], combinational.
- d_out_b  out  16  reg[rd_addr_b], combinational.
- cout  out  1  ALU carry out, combinational.

Behaviour:
- Storage: 8 x 16-bit registers R0..R7; all are general purpose, and R0 is not hardwired.
- Reset: on a rising clk edge with reset=1, all registers become 0x0000, so d_out_a = d_out_b = 0x0000 after that edge. Reset has priority over wr. Reset applied mid-operation discards any write in that cycle.
- Read: d_out_a and d_out_b are purely combinational from current register contents. Both ports may address the same register.
- Write: on a rising edge with reset=0 and wr=1, reg[wr_addr] <= (sel ? alu_y : d_in). With wr=0 nothing changes.
- Read-during-write: a read of the register being written returns the old value until the edge, then the new value. There is no bypass.
- ALU operands: A = d_out_a, B = d_out_b. The ALU is combinational and always active, independent of sel and wr.
- op=00 ADD: {cout, y} = A + B as a 17-bit sum; y wraps mod 2^16.
- op=01 SUB: {cout, y} = A + ~B + 1. cout=1 means no borrow (A >= B unsigned), cout=0 means borrow.
- op=10 AND: y = A & B, cout = 0.
- op=11 OR: y = A | B, cout = 0.
- A write with sel=1 may target one of its own source registers; the operands are the pre-edge values.
- Latency: reads and ALU have 0 cycles; a write is visible one edge later.
- Undriven or X addresses are not required to produce defined data, but must never corrupt non-addressed registers.

Test Plan:
- Reset, then write d_in (sel=0, wr=1): R3<=0xCDEF, R7<=0x3210, R5<=0x4567, R1<=0xBA98, one per cycle. Then read A=3, B=7 -> d_out_a=0xCDEF, d_out_b=0x3210.
- ADD: sel=1, op=00, A=R1(0xBA98), B=R5(0x4567), wr_addr=3 -> cout=0 before the edge; R3=0xFFFF after. Also R3(0xFFFF)+R1(0x0001 scenario) -> result 0x0000, cout=1.
- SUB: sel=1, op=01, A=R5(0x4567), B=R7(0x3210), wr_addr=7 -> R7=0x1357, cout=1. Swapped operands (0x3210-0x4567) -> 0xECA9, cout=0.
- AND then OR:
  - op=10, A=R3(0xFFFF), B=R7(0x1357), wr_addr=5 -> R5=0x1357.
  - op=11, A=R1(0xBA98), B=R5(0x1357), wr_addr=1 -> R1=0xBBDF.
  - cout=0 for both.
- Write-disable / read-during-write:
  - wr=0 with any sel/op leaves all registers unchanged.
  - Writing R2 while reading R2 shows the old value until the edge, the new value after.
- Reset mid-stream: assert reset with wr=1 and wr_addr=4, d_in=0xAAAA -> after the edge all registers read 0x0000, including R4.
